// File: rtl/encode_mac_pkg.sv
// Shared types and helpers for the encoder multiply-accumulate pipe.
// Clamping is done on a wide common width so one function serves every stage.
package encode_mac_pkg;

  localparam int DIN0_W_DEF = 40;
  localparam int DIN1_W_DEF = 28;
  localparam int PROD_W_DEF = DIN0_W_DEF + DIN1_W_DEF;
  localparam int CLAMP_W    = 128;

  typedef struct packed {
    logic valid;
    logic clr;
    logic last;
  } sideband_t;

  // Clamp a sign-extended value to the signed range of 'width' bits.
  function automatic logic signed [CLAMP_W-1:0] sat_clamp(
    input  logic signed [CLAMP_W-1:0] value,
    input  int                        width,
    output logic                      hit
  );
    logic signed [CLAMP_W-1:0] hi;
    logic signed [CLAMP_W-1:0] lo;
    hi  = (CLAMP_W'(1) <<< (width - 1)) - CLAMP_W'(1);
    lo  = ~hi;
    hit = 1'b0;
    if (value > hi) begin
      hit = 1'b1;
      return hi;
    end
    if (value < lo) begin
      hit = 1'b1;
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/encode_mac_round_sat.sv
// Combinational output conditioning: round-half-up, arithmetic shift, clamp
// to the output width. The rounding add has one bit of headroom over the accumulator.
module encode_mac_round_sat
  import encode_mac_pkg::*;
#(
  parameter int ACC_WIDTH  = 72,
  parameter int SHIFT      = 24,
  parameter int DOUT_WIDTH = 32
) (
  input  logic signed [ACC_WIDTH-1:0]  acc_i,
  output logic signed [DOUT_WIDTH-1:0] dout_o,
  output logic                         clamp_o
);

  localparam int SUM_W  = ACC_WIDTH + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [SUM_W-1:0] RND = SUM_W'(SHIFT > 0) << RND_SH;

  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   shr;
  logic signed [CLAMP_W-1:0] clamped;
  logic                      unused_hi;

  always_comb begin
    sum     = SUM_W'(acc_i) + RND;
    shr     = sum >>> SHIFT;
    clamped = sat_clamp(CLAMP_W'(shr), DOUT_WIDTH, clamp_o);
    dout_o  = clamped[DOUT_WIDTH-1:0];
  end

  assign unused_hi = ^clamped[CLAMP_W-1:DOUT_WIDTH];

endmodule

// File: rtl/encode_mac_pipe.sv
// Signed multiply-accumulate with configurable product pipe, tagged sums,
// saturating accumulator and rounded/saturated output register.
module encode_mac_pipe
  import encode_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = DIN0_W_DEF,
  parameter int DIN1_WIDTH = DIN1_W_DEF,
  parameter int NUM_STAGE  = 3,
  parameter int ACC_WIDTH  = PROD_W_DEF + 4,
  parameter int SHIFT      = 24,
  parameter int DOUT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         acc_clr,
  input  logic                         acc_last,
  output logic                         out_valid,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         sat_flag,
  output logic                         busy
);

  localparam int PROD_W = DIN0_WIDTH + DIN1_WIDTH;

  logic signed [DIN0_WIDTH-1:0] din0_q;
  logic signed [DIN1_WIDTH-1:0] din1_q;
  sideband_t                    in_sb_q;
  logic signed [PROD_W-1:0]     prod;
  logic [NUM_STAGE-1:0]         pipe_vld;

  // Input capture: the multiplier works from registered operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      din0_q  <= '0;
      din1_q  <= '0;
      in_sb_q <= '0;
    end else if (ce) begin
      din0_q  <= din0;
      din1_q  <= din1;
      in_sb_q <= '{valid: in_valid, clr: in_valid & acc_clr, last: in_valid & acc_last};
    end
  end

  assign prod = PROD_W'(din0_q) * PROD_W'(din1_q);

  for (genvar g = 0; g < NUM_STAGE; g++) begin : g_pipe
    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q;
    sideband_t                sb_d;
    sideband_t                sb_q;

    if (g == 0) begin : g_head
      assign prod_d = prod;
      assign sb_d   = in_sb_q;
    end else begin : g_body
      assign prod_d = g_pipe[g-1].prod_q;
      assign sb_d   = g_pipe[g-1].sb_q;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        prod_q <= '0;
        sb_q   <= '0;
      end else if (ce) begin
        prod_q <= prod_d;
        sb_q   <= sb_d;
      end
    end

    assign pipe_vld[g] = sb_q.valid;
  end

  // Accumulate stage: a sample without an open sum starts a new one.
  logic signed [PROD_W-1:0]    tail_prod;
  sideband_t                   tail_sb;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        ovf_q, ovf_d;
  logic                        open_q, open_d;
  logic                        pend_q, pend_d;
  logic                        start;
  logic                        acc_hit;
  logic signed [CLAMP_W-1:0]   sum;
  logic signed [CLAMP_W-1:0]   sum_sat;
  logic                        unused_hi;

  assign tail_prod = g_pipe[NUM_STAGE-1].prod_q;
  assign tail_sb   = g_pipe[NUM_STAGE-1].sb_q;

  always_comb begin
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    open_d  = open_q;
    pend_d  = 1'b0;
    start   = tail_sb.clr | ~open_q;
    sum     = start ? CLAMP_W'(tail_prod) : CLAMP_W'(acc_q) + CLAMP_W'(tail_prod);
    sum_sat = sat_clamp(sum, ACC_WIDTH, acc_hit);
    if (tail_sb.valid) begin
      acc_d  = sum_sat[ACC_WIDTH-1:0];
      ovf_d  = ~start & (ovf_q | acc_hit);
      open_d = ~tail_sb.last;
      pend_d = tail_sb.last;
    end
  end

  assign unused_hi = ^sum_sat[CLAMP_W-1:ACC_WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      open_q <= 1'b0;
      pend_q <= 1'b0;
    end else if (ce) begin
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      open_q <= open_d;
      pend_q <= pend_d;
    end
  end

  // Output stage: samples the finished sum while the accumulator may already restart.
  logic signed [DOUT_WIDTH-1:0] rs_dout;
  logic                         rs_clamp;
  logic signed [DOUT_WIDTH-1:0] dout_q;
  logic                         sat_q;
  logic                         vld_q;

  encode_mac_round_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .SHIFT      (SHIFT),
    .DOUT_WIDTH (DOUT_WIDTH)
  ) u_round_sat (
    .acc_i   (acc_q),
    .dout_o  (rs_dout),
    .clamp_o (rs_clamp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
      sat_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else if (ce) begin
      vld_q <= pend_q;
      if (pend_q) begin
        dout_q <= rs_dout;
        sat_q  <= ovf_q | rs_clamp;
      end
    end
  end

  assign out_valid = vld_q;
  assign dout      = dout_q;
  assign sat_flag  = sat_q;
  assign busy      = (|pipe_vld) | in_sb_q.valid | open_q | pend_q;

endmodule
